// File: rtl/gather.sv
// Width-gathering stage: packs N consecutive W-bit slave words into one N*W-bit beat.
// A second completed beat can wait in the accumulator while the output register is stalled.
module gather #(
    parameter int W = 8,
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_stb,
    input  logic [W-1:0]   s_dat,
    output logic           s_rdy,
    output logic           m_stb,
    input  logic           m_rdy,
    output logic [N*W-1:0] m_dat
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0]  idx_q, idx_d;
    logic [N*W-1:0] acc_q, acc_d;
    logic           accFull_q, accFull_d;
    logic [N*W-1:0] out_q, out_d;
    logic           mStb_q, mStb_d;

    logic           accept;
    logic           drain;
    logic           outFree;
    logic           lastLane;
    logic [N*W-1:0] accNew;

    assign s_rdy    = !accFull_q;
    assign m_stb    = mStb_q;
    assign m_dat    = out_q;

    assign accept   = s_stb && !accFull_q;
    assign drain    = mStb_q && m_rdy;
    assign outFree  = !mStb_q || m_rdy;
    assign lastLane = (idx_q == IW'(N - 1));

    always_comb begin
        accNew = acc_q;
        for (int k = 0; k < N; k++) begin
            if (idx_q == IW'(k)) begin
                accNew[k*W +: W] = s_dat;
            end
        end
    end

    always_comb begin
        idx_d     = idx_q;
        acc_d     = acc_q;
        accFull_d = accFull_q;
        out_d     = out_q;
        mStb_d    = mStb_q;

        if (accept) begin
            acc_d = accNew;
            idx_d = lastLane ? '0 : idx_q + IW'(1);
        end

        // A parked beat has priority; s_rdy is low then, so no word competes with it.
        if (accFull_q && drain) begin
            out_d     = acc_q;
            mStb_d    = 1'b1;
            accFull_d = 1'b0;
        end else if (accept && lastLane && outFree) begin
            out_d  = accNew;
            mStb_d = 1'b1;
        end else if (accept && lastLane) begin
            accFull_d = 1'b1;
        end else if (drain) begin
            mStb_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q     <= '0;
            acc_q     <= '0;
            accFull_q <= 1'b0;
            out_q     <= '0;
            mStb_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            accFull_q <= accFull_d;
            out_q     <= out_d;
            mStb_q    <= mStb_d;
        end
    end

endmodule

// File: tb/tb_gather.sv
// Bench for gather: directed scenarios plus random traffic, checked against a beat-queue model.
module tb_gather;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sStb = 1'b0;
    logic [7:0]  sDat = '0;
    logic        sRdy;
    logic        mStb;
    logic        mRdy = 1'b0;
    logic [15:0] mDat;

    logic        s4Stb = 1'b0;
    logic [7:0]  s4Dat = '0;
    logic        s4Rdy;
    logic        m4Stb;
    logic        m4Rdy = 1'b0;
    logic [31:0] m4Dat;

    int tests = 0;
    int fails = 0;

    logic [7:0]  part[$];
    logic [15:0] pend[$];

    always #5 clk = ~clk;

    gather #(.W(8), .N(2)) dut (
        .clk(clk), .rst(rst),
        .s_stb(sStb), .s_dat(sDat), .s_rdy(sRdy),
        .m_stb(mStb), .m_rdy(mRdy), .m_dat(mDat)
    );

    gather #(.W(8), .N(4)) dut4 (
        .clk(clk), .rst(rst),
        .s_stb(s4Stb), .s_dat(s4Dat), .s_rdy(s4Rdy),
        .m_stb(m4Stb), .m_rdy(m4Rdy), .m_dat(m4Dat)
    );

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model view: at most two completed beats can be outstanding (output register + accumulator).
    task automatic checkOutput(input string tag);
        checkValue({tag, " s_rdy"}, 64'(sRdy), 64'(pend.size() < 2));
        checkValue({tag, " m_stb"}, 64'(mStb), 64'(pend.size() > 0));
        if (pend.size() > 0) begin
            checkValue({tag, " m_dat"}, 64'(mDat), 64'(pend[0]));
        end
    endtask

    task automatic applyStimulus(input logic stb, input logic [7:0] dat, input logic rdy, input string tag);
        bit doAccept;
        bit doDrain;
        sStb = stb;
        sDat = dat;
        mRdy = rdy;
        @(posedge clk);
        doAccept = stb && (pend.size() < 2);
        doDrain  = rdy && (pend.size() > 0);
        if (doDrain) void'(pend.pop_front());
        if (doAccept) begin
            part.push_back(dat);
            if (part.size() == 2) begin
                pend.push_back({part[1], part[0]});
                part.delete();
            end
        end
        @(negedge clk);
        checkOutput(tag);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkValue("reset m_stb", 64'(mStb), 64'd0);
        checkValue("reset s_rdy", 64'(sRdy), 64'd1);
        checkValue("reset m_dat", 64'(mDat), 64'd0);
        checkValue("reset n4 m_stb", 64'(m4Stb), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus(1'b1, 8'h11, 1'b1, "first word");
        applyStimulus(1'b1, 8'h22, 1'b1, "second word");
        checkValue("single beat", 64'(mDat), 64'h2211);
        applyStimulus(1'b0, 8'h00, 1'b1, "beat drained");
        checkValue("single beat one cycle", 64'(mStb), 64'd0);

        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1, "streaming");
            checkValue("streaming s_rdy", 64'(sRdy), 64'd1);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, "stream tail");

        applyStimulus(1'b1, 8'hA1, 1'b0, "stall A1");
        applyStimulus(1'b1, 8'hA2, 1'b0, "stall A2");
        applyStimulus(1'b1, 8'hB1, 1'b0, "stall B1");
        applyStimulus(1'b1, 8'hB2, 1'b0, "stall B2");
        checkValue("stall s_rdy low", 64'(sRdy), 64'd0);
        applyStimulus(1'b1, 8'hC1, 1'b0, "fifth refused");
        checkValue("stall holds A", 64'(mDat), 64'hA2A1);
        applyStimulus(1'b0, 8'h00, 1'b1, "release A");
        checkValue("release gives B", 64'(mDat), 64'hB2B1);
        checkValue("s_rdy back", 64'(sRdy), 64'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, "release B");

        applyStimulus(1'b1, 8'h31, 1'b0, "fill 31");
        applyStimulus(1'b1, 8'h32, 1'b0, "fill 32");
        applyStimulus(1'b1, 8'h41, 1'b0, "overlap 41");
        applyStimulus(1'b1, 8'h42, 1'b1, "overlap 42");
        checkValue("overlap m_dat", 64'(mDat), 64'h4241);
        checkValue("overlap s_rdy", 64'(sRdy), 64'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, "overlap drain");

        applyStimulus(1'b1, 8'h55, 1'b0, "pre-reset 55");
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkValue("async reset m_stb", 64'(mStb), 64'd0);
        checkValue("async reset s_rdy", 64'(sRdy), 64'd1);
        checkValue("async reset m_dat", 64'(mDat), 64'd0);
        part.delete();
        pend.delete();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 8'h33, 1'b1, "post-reset 33");
        applyStimulus(1'b1, 8'h44, 1'b1, "post-reset 44");
        checkValue("post-reset beat", 64'(mDat), 64'h4433);
        applyStimulus(1'b0, 8'h00, 1'b1, "post-reset drain");

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0), "random");
        end
        sStb = 1'b0;

        for (int i = 1; i <= 4; i++) begin
            s4Stb = 1'b1;
            s4Dat = 8'(i);
            @(negedge clk);
        end
        s4Stb = 1'b0;
        checkValue("n4 m_stb", 64'(m4Stb), 64'd1);
        checkValue("n4 m_dat", 64'(m4Dat), 64'h04030201);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
